// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounced press/release and registered key-code output.
// kb_idx[4] is the key-valid level and kb_idx[3:0] holds the last accepted key code.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] kb_idx
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEB_CNT);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  // The detecting cycle counts as the first stable one, so the counter stops DEB_CNT-2 past entry.
  localparam logic [BW-1:0] DEB_LAST = BW'(DEB_CNT - 2);
  localparam logic [63:0] KEYMAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HOLD, DEB_REL} state_t;
  state_t        state_q;
  logic [3:0]    sync_q, rs_q, pat_q, code_q, col_out_q;
  logic [1:0]    col_q, low_row;
  logic [DW-1:0] div_q;
  logic [BW-1:0] deb_q;
  logic [4:0]    kb_q;
  logic [3:0]    key_code;
  assign low_row  = !rs_q[0] ? 2'd0 : !rs_q[1] ? 2'd1 : !rs_q[2] ? 2'd2 : 2'd3;
  assign key_code = KEYMAP[{low_row, col_q, 2'b00} +: 4];
  assign col_out  = col_out_q;
  assign kb_idx   = kb_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 4'hF;
      rs_q      <= 4'hF;
      state_q   <= SCAN;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      div_q     <= '0;
      deb_q     <= '0;
      pat_q     <= 4'hF;
      code_q    <= 4'h0;
      kb_q      <= 5'h00;
    end else begin
      sync_q <= row_in;
      rs_q   <= sync_q;
      case (state_q)
        SCAN:
          if (div_q != DIV_LAST) div_q <= div_q + DW'(1);
          else begin
            div_q <= '0;
            if (rs_q != 4'hF) begin
              state_q <= DEB_PRESS;
              pat_q   <= rs_q;
              code_q  <= key_code;
              deb_q   <= '0;
            end else begin
              col_q     <= col_q + 2'd1;
              col_out_q <= {col_out_q[2:0], col_out_q[3]};
            end
          end
        DEB_PRESS:
          if (rs_q != pat_q) begin
            state_q   <= SCAN;
            deb_q     <= '0;
            col_q     <= col_q + 2'd1;
            col_out_q <= {col_out_q[2:0], col_out_q[3]};
          end else if (deb_q == DEB_LAST) begin
            state_q <= HOLD;
            kb_q    <= {1'b1, code_q};
            deb_q   <= '0;
          end else deb_q <= deb_q + BW'(1);
        HOLD:
          if (rs_q == 4'hF) begin
            state_q <= DEB_REL;
            deb_q   <= '0;
          end
        DEB_REL:
          if (rs_q != 4'hF) begin
            state_q <= HOLD;
            deb_q   <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q   <= SCAN;
            kb_q[4]   <= 1'b0;
            deb_q     <= '0;
            col_q     <= col_q + 2'd1;
            col_out_q <= {col_out_q[2:0], col_out_q[3]};
          end else deb_q <= deb_q + BW'(1);
        default: state_q <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a physical keypad matrix model,
// a cycle-level behavioural reference compared every cycle, and pinned literal expectations.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DEB_CNT  = 8;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_in, col_out;
  logic [4:0]  kb_idx;
  logic [15:0] pressed;
  int errors = 0;
  int checks = 0;
  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .kb_idx(kb_idx)
  );
  always #5 clk = ~clk;
  // Key (r,c) at pressed[r*4+c] pulls row r low while column c is driven low.
  always_comb for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int m_phase, m_col, m_tick, m_stable, m_code;
  logic [3:0] m_s0, m_s1, m_pat, rin_hold;
  logic [4:0] m_kb;
  logic rst_hold;
  function automatic int lowest(input logic [3:0] v);
    for (int r = 0; r < 4; r++) if (!v[r]) return r;
    return 0;
  endfunction
  task automatic model_step();
    if (rst_hold || rst) begin
      m_phase = 0; m_col = 0; m_tick = 0; m_stable = 0; m_code = 0;
      m_s0 = 4'hF; m_s1 = 4'hF; m_pat = 4'hF; m_kb = 5'h00;
    end else begin
      case (m_phase)
        0: begin
          m_tick++;
          if (m_tick == SCAN_DIV) begin
            m_tick = 0;
            if (m_s1 != 4'hF) begin
              m_phase = 1; m_stable = 1; m_pat = m_s1;
              m_code = keymap[lowest(m_s1)][m_col];
            end else m_col = (m_col + 1) % 4;
          end
        end
        1: if (m_s1 == m_pat) begin
             m_stable++;
             if (m_stable == DEB_CNT) begin m_phase = 2; m_kb = {1'b1, 4'(m_code)}; end
           end else begin m_phase = 0; m_col = (m_col + 1) % 4; end
        2: if (m_s1 == 4'hF) begin m_phase = 3; m_stable = 1; end
        default: if (m_s1 == 4'hF) begin
             m_stable++;
             if (m_stable == DEB_CNT) begin m_phase = 0; m_kb[4] = 1'b0; m_col = (m_col + 1) % 4; end
           end else m_phase = 2;
      endcase
      m_s1 = m_s0;
      m_s0 = rin_hold;
    end
  endtask
  initial begin
    rin_hold = 4'hF;
    rst_hold = 1'b1;
    forever begin
      @(negedge clk);
      model_step();
      check("model_col", 8'(col_out), 8'(4'hF ^ 4'(1 << m_col)));
      check("model_kb", 8'(kb_idx), 8'(m_kb));
      #1;
      rin_hold = row_in;
      rst_hold = rst;
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_kb(input logic [4:0] v, input int lim, input string name);
    int k = 0;
    while (kb_idx !== v && k < lim) begin @(negedge clk); k++; end
    check(name, 8'(kb_idx), 8'(v));
  endtask
  initial begin
    int k;
    rst = 1'b1;
    pressed = '0;
    cyc(3);
    check("reset_col", 8'(col_out), 8'h0E);
    check("reset_kb", 8'(kb_idx), 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("scan_col", 8'(col_out), 8'(4'hF ^ (4'h1 << ((i + 1) / 4 % 4))));
    end
    pressed[5] = 1'b1;
    wait_kb(5'h15, 28, "press5");
    cyc(20);
    check("hold5_kb", 8'(kb_idx), 8'h15);
    check("hold5_col", 8'(col_out), 8'h0D);
    pressed[5] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      if (j == 9) check("rel_k9", 8'(kb_idx), 8'h15);
      if (j == 10) check("rel_k10", 8'(kb_idx), 8'h05);
    end
    pressed[5] = 1'b1;
    wait_kb(5'h15, 40, "repress5");
    cyc(2);
    pressed[5] = 1'b0;
    cyc(5);
    pressed[5] = 1'b1;
    cyc(1);
    pressed[5] = 1'b0;
    cyc(4);
    check("glitch_k10", 8'(kb_idx), 8'h15);
    cyc(5);
    check("glitch_k15", 8'(kb_idx), 8'h15);
    cyc(1);
    check("glitch_k16", 8'(kb_idx), 8'h05);
    k = 0;
    while (col_out == 4'b1011 && k < 20) begin cyc(1); k++; end
    while (col_out != 4'b1011 && k < 40) begin cyc(1); k++; end
    check("find_col2", 8'(col_out), 8'h0B);
    pressed[14] = 1'b1;
    cyc(3);
    pressed[14] = 1'b0;
    cyc(3);
    check("bounce_col3", 8'(col_out), 8'h07);
    check("bounce_kb", 8'(kb_idx), 8'h05);
    cyc(20);
    check("bounce_kb_late", 8'(kb_idx), 8'h05);
    pressed[0] = 1'b1;
    pressed[4] = 1'b1;
    wait_kb(5'h11, 40, "press1_4");
    pressed[0] = 1'b0;
    cyc(20);
    check("hold_extra_kb", 8'(kb_idx), 8'h11);
    check("hold_extra_col", 8'(col_out), 8'h0E);
    pressed[4] = 1'b0;
    wait_kb(5'h01, 20, "release4");
    pressed[5] = 1'b1;
    wait_kb(5'h15, 40, "press5_hold");
    cyc(3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_kb", 8'(kb_idx), 8'h00);
    check("async_rst_col", 8'(col_out), 8'h0E);
    cyc(3);
    rst = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      cyc(1);
      if (j == 14) check("reaccept_k14", 8'(kb_idx), 8'h00);
      if (j == 15) check("reaccept_k15", 8'(kb_idx), 8'h15);
    end
    pressed = '0;
    cyc(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
